// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the tic-tac-toe game controller
package ttt_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_WAIT,
        ST_SET,
        ST_CHECK,
        ST_OVER
    } state_t;

    localparam logic SYM_X     = 1'b0;
    localparam logic SYM_O     = 1'b1;
    localparam int   NUM_CELLS = 9;
    localparam int   NUM_LINES = 8;

    // Cell triples indexed by win_line bit: rows 0-2, columns 3-5, diagonals 6-7.
    localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational evaluation of the eight winning lines
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] cell_valid,
    input  logic [8:0] cell_symbol,
    output logic [7:0] x_lines,
    output logic [7:0] o_lines
);

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        logic [2:0] w_v;
        logic [2:0] w_s;
        for (genvar k = 0; k < 3; k++) begin : g_cell
            assign w_v[k] = cell_valid[WIN_LINES[l][k]];
            assign w_s[k] = cell_symbol[WIN_LINES[l][k]];
        end
        assign x_lines[l] = (&w_v) && (w_s == {3{SYM_X}});
        assign o_lines[l] = (&w_v) && (w_s == {3{SYM_O}});
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - turn, move legality and result FSM for a nine-cell board
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_req,
    input  logic [3:0] p0_pos,
    input  logic       p1_req,
    input  logic [3:0] p1_pos,
    input  logic       new_game,
    input  logic [8:0] cell_valid,
    input  logic [8:0] cell_symbol,
    output logic [8:0] cell_set,
    output logic       set_symbol,
    output logic       cells_reset,
    output logic       turn,
    output logic       move_ack,
    output logic       illegal,
    output logic       game_over,
    output logic       win,
    output logic       draw,
    output logic       winner,
    output logic [7:0] win_line
);

    state_t     r_state, w_state_nxt;
    logic [8:0] r_cell_set, w_cell_set_nxt;
    logic       r_set_symbol, w_set_symbol_nxt;
    logic       r_cells_reset, w_cells_reset_nxt;
    logic       r_turn, w_turn_nxt;
    logic       r_move_ack, w_move_ack_nxt;
    logic       r_illegal, w_illegal_nxt;
    logic       r_game_over, w_game_over_nxt;
    logic       r_win, w_win_nxt;
    logic       r_draw, w_draw_nxt;
    logic       r_winner, w_winner_nxt;
    logic [7:0] r_win_line, w_win_line_nxt;

    logic       w_req;
    logic [3:0] w_pos;
    logic [8:0] w_onehot;
    logic       w_legal;
    logic [7:0] w_x_lines, w_o_lines;
    logic       w_won, w_full;

    ttt_line_check u_line_check (
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .x_lines     (w_x_lines),
        .o_lines     (w_o_lines)
    );

    // Only the player whose turn it is gets looked at; the other request is dropped silently.
    assign w_req    = (r_turn == SYM_O) ? p1_req : p0_req;
    assign w_pos    = (r_turn == SYM_O) ? p1_pos : p0_pos;
    assign w_onehot = 9'b1 << w_pos;
    assign w_legal  = (w_pos < 4'(NUM_CELLS)) && ((w_onehot & cell_valid) == 9'b0);
    assign w_won    = |(w_x_lines | w_o_lines);
    assign w_full   = &cell_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_CLEAR;
            r_cell_set    <= '0;
            r_set_symbol  <= 1'b0;
            r_cells_reset <= 1'b0;
            r_turn        <= FIRST_PLAYER;
            r_move_ack    <= 1'b0;
            r_illegal     <= 1'b0;
            r_game_over   <= 1'b0;
            r_win         <= 1'b0;
            r_draw        <= 1'b0;
            r_winner      <= 1'b0;
            r_win_line    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cell_set    <= w_cell_set_nxt;
            r_set_symbol  <= w_set_symbol_nxt;
            r_cells_reset <= w_cells_reset_nxt;
            r_turn        <= w_turn_nxt;
            r_move_ack    <= w_move_ack_nxt;
            r_illegal     <= w_illegal_nxt;
            r_game_over   <= w_game_over_nxt;
            r_win         <= w_win_nxt;
            r_draw        <= w_draw_nxt;
            r_winner      <= w_winner_nxt;
            r_win_line    <= w_win_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = ST_CLEAR;
        end else begin
            case (r_state)
                ST_CLEAR: w_state_nxt = ST_WAIT;
                ST_WAIT:  if (w_req && w_legal) w_state_nxt = ST_SET;
                ST_SET:   w_state_nxt = ST_CHECK;
                ST_CHECK: w_state_nxt = (w_won || w_full) ? ST_OVER : ST_WAIT;
                ST_OVER:  w_state_nxt = ST_OVER;
                default:  w_state_nxt = ST_CLEAR;
            endcase
        end
    end

    // Next values of the registered outputs; pulses default low, results hold.
    always_comb begin
        w_cell_set_nxt    = '0;
        w_set_symbol_nxt  = 1'b0;
        w_cells_reset_nxt = 1'b0;
        w_move_ack_nxt    = 1'b0;
        w_illegal_nxt     = 1'b0;
        w_turn_nxt        = r_turn;
        w_game_over_nxt   = r_game_over;
        w_win_nxt         = r_win;
        w_draw_nxt        = r_draw;
        w_winner_nxt      = r_winner;
        w_win_line_nxt    = r_win_line;
        if (!new_game) begin
            case (r_state)
                ST_CLEAR: begin
                    w_cells_reset_nxt = 1'b1;
                    w_turn_nxt        = FIRST_PLAYER;
                    w_game_over_nxt   = 1'b0;
                    w_win_nxt         = 1'b0;
                    w_draw_nxt        = 1'b0;
                    w_winner_nxt      = 1'b0;
                    w_win_line_nxt    = '0;
                end
                ST_WAIT: begin
                    if (w_req && w_legal) begin
                        w_cell_set_nxt   = w_onehot;
                        w_set_symbol_nxt = r_turn;
                        w_move_ack_nxt   = 1'b1;
                    end else if (w_req) begin
                        w_illegal_nxt    = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_won) begin
                        w_game_over_nxt = 1'b1;
                        w_win_nxt       = 1'b1;
                        w_winner_nxt    = (|w_x_lines) ? SYM_X : SYM_O;
                        w_win_line_nxt  = w_x_lines | w_o_lines;
                    end else if (w_full) begin
                        w_game_over_nxt = 1'b1;
                        w_draw_nxt      = 1'b1;
                    end else begin
                        w_turn_nxt      = ~r_turn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cell_set    = r_cell_set;
    assign set_symbol  = r_set_symbol;
    assign cells_reset = r_cells_reset;
    assign turn        = r_turn;
    assign move_ack    = r_move_ack;
    assign illegal     = r_illegal;
    assign game_over   = r_game_over;
    assign win         = r_win;
    assign draw        = r_draw;
    assign winner      = r_winner;
    assign win_line    = r_win_line;

endmodule
